// File: rtl/my_uart_top.sv
// UART 8N1 echo: every byte received on rs232_rx is retransmitted on rs232_tx.
// Path: two-flop synchronizer, RX FSM, one-byte holding register, TX FSM.
module my_uart_top #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rs232_rx,
  output logic rs232_tx
);

  localparam int unsigned BIT_CNT  = CLK_FREQ / BAUD;
  localparam int unsigned HALF_CNT = BIT_CNT / 2;
  localparam int unsigned CNT_W    = $clog2(BIT_CNT + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // ---------------- input synchronizer ----------------
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;
  logic rx_fall_c;

  // Two-flop synchronizer plus one delay stage for edge detection; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rs232_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall_c = rx_prev & ~rx_sync;

  // ---------------- receiver ----------------
  rx_state_t        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]       rx_idx, rx_idx_nxt;
  logic [7:0]       rx_data, rx_data_nxt;
  logic             rx_done, rx_done_nxt;

  // RX state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_data  <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_idx   <= rx_idx_nxt;
      rx_data  <= rx_data_nxt;
      rx_done  <= rx_done_nxt;
    end
  end

  // RX next state: centre-sample start, data (LSB first) and stop bits.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_idx_nxt   = rx_idx;
    rx_data_nxt  = rx_data;
    rx_done_nxt  = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_fall_c) begin
          rx_state_nxt = RX_START;
          rx_cnt_nxt   = CNT_ZERO;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nxt = CNT_ZERO;
          if (!rx_sync) begin
            rx_state_nxt = RX_DATA;
            rx_idx_nxt   = 3'd0;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            rx_state_nxt = RX_IDLE;
          end
        end else begin
          rx_cnt_nxt = rx_cnt + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt  = CNT_ZERO;
          rx_data_nxt = {rx_sync, rx_data[7:1]};
          if (rx_idx == 3'd7) begin
            rx_state_nxt = RX_STOP;
          end else begin
            rx_idx_nxt = rx_idx + 3'd1;
          end
        end else begin
          rx_cnt_nxt = rx_cnt + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = CNT_ZERO;
          // A low stop bit is a framing error; the byte is dropped.
          rx_done_nxt  = rx_sync;
          rx_state_nxt = RX_IDLE;
        end else begin
          rx_cnt_nxt = rx_cnt + CNT_ONE;
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // ---------------- holding register + transmitter ----------------
  tx_state_t        tx_state, tx_state_nxt;
  logic [CNT_W-1:0] tx_cnt, tx_cnt_nxt;
  logic [2:0]       tx_idx, tx_idx_nxt;
  logic [7:0]       tx_shift, tx_shift_nxt;
  logic             tx_out, tx_out_nxt;
  logic [7:0]       hold_data, hold_data_nxt;
  logic             hold_full, hold_full_nxt;

  // TX state, shift register, holding register and the line driver flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= TX_IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_shift  <= '0;
      tx_out    <= 1'b1;
      hold_data <= '0;
      hold_full <= 1'b0;
    end else begin
      tx_state  <= tx_state_nxt;
      tx_cnt    <= tx_cnt_nxt;
      tx_idx    <= tx_idx_nxt;
      tx_shift  <= tx_shift_nxt;
      tx_out    <= tx_out_nxt;
      hold_data <= hold_data_nxt;
      hold_full <= hold_full_nxt;
    end
  end

  // TX next state, byte handoff from RX, and next line level.
  always_comb begin
    tx_state_nxt  = tx_state;
    tx_cnt_nxt    = tx_cnt;
    tx_idx_nxt    = tx_idx;
    tx_shift_nxt  = tx_shift;
    hold_data_nxt = hold_data;
    hold_full_nxt = hold_full;
    tx_out_nxt    = 1'b1;
    unique case (tx_state)
      TX_IDLE: begin
        // A held byte is older than one arriving now, so it goes first.
        if (hold_full) begin
          tx_shift_nxt  = hold_data;
          hold_full_nxt = 1'b0;
          tx_state_nxt  = TX_START;
          tx_cnt_nxt    = CNT_ZERO;
        end else if (rx_done) begin
          tx_shift_nxt = rx_data;
          tx_state_nxt = TX_START;
          tx_cnt_nxt   = CNT_ZERO;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = CNT_ZERO;
          tx_idx_nxt   = 3'd0;
          tx_state_nxt = TX_DATA;
        end else begin
          tx_cnt_nxt = tx_cnt + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = CNT_ZERO;
          tx_shift_nxt = {1'b0, tx_shift[7:1]};
          if (tx_idx == 3'd7) begin
            tx_state_nxt = TX_STOP;
          end else begin
            tx_idx_nxt = tx_idx + 3'd1;
          end
        end else begin
          tx_cnt_nxt = tx_cnt + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = CNT_ZERO;
          tx_state_nxt = TX_IDLE;
        end else begin
          tx_cnt_nxt = tx_cnt + CNT_ONE;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase

    // Byte not taken directly by TX is parked; newest overwrites.
    if (rx_done && !((tx_state == TX_IDLE) && !hold_full)) begin
      hold_data_nxt = rx_data;
      hold_full_nxt = 1'b1;
    end

    unique case (tx_state_nxt)
      TX_START: tx_out_nxt = 1'b0;
      TX_DATA:  tx_out_nxt = tx_shift_nxt[0];
      default:  tx_out_nxt = 1'b1;
    endcase
  end

  assign rs232_tx = tx_out;

endmodule

// File: tb/tb_my_uart_top.sv
// Self-checking bench for the UART echo block, run at a scaled-down bit rate.
module tb_my_uart_top;

  localparam int unsigned CLK_FREQ = 120;
  localparam int unsigned BAUD     = 10;
  localparam int          BIT      = 12;
  localparam int          HALF     = 6;
  localparam int          FRAME    = 10 * BIT;

  logic clk;
  logic rst_n;
  logic rs232_rx;
  logic rs232_tx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rx_start_cyc = 0;

  typedef struct {
    logic [7:0] data;
    bit         shape_ok;
    int         start_cyc;
  } echo_t;

  logic [7:0] exp_q[$];
  echo_t      got_q[$];

  my_uart_top #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs232_rx (rs232_rx),
    .rs232_tx (rs232_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Frame decoder on rs232_tx: samples every clock, checks exact bit widths.
  logic samp [FRAME];
  initial begin
    logic  prev;
    bit    aborted;
    echo_t e;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !rs232_tx) begin
        e.start_cyc = cyc;
        aborted = 1'b0;
        samp[0] = rs232_tx;
        for (int j = 1; j < FRAME; j++) begin
          @(negedge clk);
          samp[j] = rs232_tx;
          if (!rst_n) aborted = 1'b1;
        end
        prev = samp[FRAME-1];
        e.shape_ok = (samp[0] == 1'b0) && (samp[9*BIT] == 1'b1);
        for (int b = 0; b < 10; b++)
          for (int k = 1; k < BIT; k++)
            if (samp[b*BIT+k] !== samp[b*BIT]) e.shape_ok = 1'b0;
        for (int b = 0; b < 8; b++) e.data[b] = samp[(b+1)*BIT];
        if (!aborted) got_q.push_back(e);
      end else begin
        prev = rs232_tx;
      end
    end
  end

  // Drive one frame; stop_bit=0 produces a framing error.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input bit push);
    logic [9:0] f;
    f = {stop_bit, d, 1'b0};
    if (push) exp_q.push_back(d);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rs232_rx = f[i];
      if (i == 0) rx_start_cyc = cyc;
      repeat (BIT - 1) @(negedge clk);
    end
  endtask

  task automatic wait_echo(output bit got);
    got = 1'b0;
    for (int i = 0; i < 30 * BIT; i++) begin
      if (got_q.size() > 0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Pop one echo and compare against the scoreboard head.
  task automatic collect_one(input string name);
    bit         got;
    echo_t      e;
    logic [7:0] x;
    wait_echo(got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: timeout, no echo frame seen, required one", name);
    end else begin
      e = got_q.pop_front();
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s: unexpected echo 0x%02h, required none", name, e.data);
      end else begin
        x = exp_q.pop_front();
        if (e.data !== x) begin
          errors++;
          $display("FAIL %s data: got 0x%02h, required 0x%02h", name, e.data, x);
        end
        checks++;
        if (e.shape_ok !== 1'b1) begin
          errors++;
          $display("FAIL %s shape: start/stop/bit widths wrong for 0x%02h, required %0d clocks/bit",
                   name, x, BIT);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rs232_rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rs232_tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx: got %b, required 1", rs232_tx);
    end
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    checks++;
    if (rs232_tx !== 1'b1 || got_q.size() != 0) begin
      errors++;
      $display("FAIL idle_after_reset: tx %b frames %0d, required 1 and 0", rs232_tx, got_q.size());
    end
  endtask

  task automatic test_single;
    bit    got;
    echo_t e;
    int    lat;
    send_frame(8'hA5, 1'b1, 1'b1);
    wait_echo(got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL single: timeout, no echo, required 0xa5");
    end else begin
      e = got_q[0];
      lat = e.start_cyc - rx_start_cyc;
      if (lat < HALF + 9*BIT + 1 || lat > HALF + 9*BIT + 4) begin
        errors++;
        $display("FAIL single latency: got %0d clocks, required %0d..%0d",
                 lat, HALF + 9*BIT + 1, HALF + 9*BIT + 4);
      end
    end
    collect_one("single");
  endtask

  task automatic test_sweep;
    fork
      for (int b = 0; b < 256; b++) begin
        send_frame(8'(b), 1'b1, 1'b1);
        repeat (4 * BIT) @(negedge clk);
      end
      for (int b = 0; b < 256; b++) collect_one("sweep");
    join
  endtask

  task automatic test_back_to_back;
    logic [7:0] pat [4];
    pat[0] = 8'h55; pat[1] = 8'hAA; pat[2] = 8'h0F; pat[3] = 8'hF0;
    fork
      for (int i = 0; i < 4; i++) send_frame(pat[i], 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) collect_one("back_to_back");
    join
  endtask

  task automatic test_glitch;
    bit quiet;
    quiet = 1'b1;
    @(negedge clk);
    rs232_rx = 1'b0;
    repeat (3) @(negedge clk);
    rs232_rx = 1'b1;
    for (int i = 0; i < 14 * BIT; i++) begin
      @(negedge clk);
      if (rs232_tx !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (!quiet || got_q.size() != 0) begin
      errors++;
      $display("FAIL glitch: tx left idle (quiet=%b frames=%0d), required quiet=1 frames=0",
               quiet, got_q.size());
    end
    send_frame(8'h3C, 1'b1, 1'b1);
    collect_one("after_glitch");
  endtask

  task automatic test_framing;
    send_frame(8'h81, 1'b0, 1'b0);
    @(negedge clk);
    rs232_rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    send_frame(8'h42, 1'b1, 1'b1);
    collect_one("framing");
    repeat (2 * BIT) @(negedge clk);
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL framing extra: got %0d extra frames, required 0", got_q.size());
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    bit high;
    seen = 1'b0;
    high = 1'b1;
    send_frame(8'h77, 1'b1, 1'b0);
    for (int i = 0; i < 30 * BIT; i++) begin
      @(negedge clk);
      if (!rs232_tx) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_mid start: no echo start bit seen, required one");
    end
    // Land inside data bit 3 of 0x77, which is low.
    repeat (4 * BIT + BIT / 2) @(negedge clk);
    checks++;
    if (rs232_tx !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid bit3: got %b, required 0", rs232_tx);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rs232_tx !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid async: got %b, required 1", rs232_tx);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12 * BIT; i++) begin
      @(negedge clk);
      if (rs232_tx !== 1'b1) high = 1'b0;
    end
    checks++;
    if (!high || got_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid after: high=%b frames=%0d, required high=1 frames=0",
               high, got_q.size());
    end
    exp_q.delete();
    got_q.delete();
    send_frame(8'h99, 1'b1, 1'b1);
    collect_one("after_reset");
  endtask

  initial begin
    rst_n    = 1'b0;
    rs232_rx = 1'b1;
    test_reset();
    test_single();
    test_sweep();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expected bytes never echoed, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
